// File: rtl/uart_pkg.sv
// uart_pkg -- constants shared by the UART transmitter and the matching receiver.
//   PAR_NONE/PAR_ODD/PAR_EVEN : values of the PARITY parameter
//   uart_state_e              : frame sequencer state encoding
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- payload handshake between a producer and uart_tx.
//   data  : payload, DATA_BITS wide (producer -> uart_tx)
//   valid : payload offered         (producer -> uart_tx)
//   ready : uart_tx can accept      (uart_tx -> producer)
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// baud_gen -- bit-period clock enable.
//   clk   : clock
//   rst   : synchronous active-high reset
//   clear : hold the counter at zero (aligns the bit period to frame start)
//   tick  : one-clock pulse on the last clock of each DIV-clock bit period
module baud_gen #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (rst || clear)
            r_cnt <= '0;
        else if (w_last)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx -- UART serial transmitter (start, DATA_BITS LSB first, optional parity, stop).
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any frame in flight
//   bus  : uart_tx_if slave (data/valid in, ready out); accepts on valid && ready
//   tx   : serial line, idle high
//   busy : frame in progress (~ready)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = PAR_NONE,
    parameter int STOP_BITS       = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_if.slave       bus,
    output logic           tx,
    output logic           busy
);
    localparam int DIV  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int IDXW = $clog2(DATA_BITS + 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDXW-1:0]      r_bit_idx;
    logic                 r_par;
    logic                 r_stop_cnt;
    logic                 w_tick;
    logic                 w_accept;
    logic                 w_tx;

    assign bus.ready = (r_state == ST_IDLE);
    assign busy      = ~bus.ready;
    assign w_accept  = bus.valid && bus.ready;
    assign tx        = w_tx;

    // Counter is held at zero throughout IDLE, so the start bit gets a full period.
    baud_gen #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .BAUD_RATE       (BAUD_RATE)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state == ST_IDLE),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = ST_START;
            end
            ST_START: begin
                w_tx = 1'b0;
                if (w_tick)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx = r_shift[0];
                if (w_tick && r_bit_idx == IDXW'(DATA_BITS - 1))
                    w_state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                w_tx = r_par;
                if (w_tick)
                    w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick && r_stop_cnt == 1'(STOP_BITS - 1))
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Parity is computed once from the accepted payload, so later data changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par      <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else if (w_accept) begin
            r_shift    <= bus.data;
            r_bit_idx  <= '0;
            r_par      <= (PARITY == PAR_EVEN) ? ^bus.data : ~^bus.data;
            r_stop_cnt <= 1'b0;
        end else if (w_tick) begin
            if (r_state == ST_DATA) begin
                r_shift <= r_shift >> 1;
                if (r_bit_idx < IDXW'(DATA_BITS))
                    r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (r_state == ST_STOP)
                r_stop_cnt <= r_stop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx in 8N1, 8E1, 8O1 and 7N2 (DIV=16).
// Expected {ready,tx} per clock is queued when a payload is offered and popped
// one entry per clock while the line is sampled 1 time unit after each rising edge.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] data_d [4];
    logic [3:0] valid_d;
    logic [3:0] tx_w, rdy_w, bsy_w;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q [$];

    int nb_t [4] = '{8, 8, 8, 7};
    int pm_t [4] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
    int sb_t [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(7)) if3 ();

    assign if0.data  = data_d[0][7:0];
    assign if1.data  = data_d[1][7:0];
    assign if2.data  = data_d[2][7:0];
    assign if3.data  = data_d[3][6:0];
    assign if0.valid = valid_d[0];
    assign if1.valid = valid_d[1];
    assign if2.valid = valid_d[2];
    assign if3.valid = valid_d[3];
    assign rdy_w     = {if3.ready, if2.ready, if1.ready, if0.ready};

    uart_tx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .bus(if0), .tx(tx_w[0]), .busy(bsy_w[0]));
    uart_tx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
        u1 (.clk(clk), .rst(rst), .bus(if1), .tx(tx_w[1]), .busy(bsy_w[1]));
    uart_tx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1))
        u2 (.clk(clk), .rst(rst), .bus(if2), .tx(tx_w[2]), .busy(bsy_w[2]));
    uart_tx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2))
        u3 (.clk(clk), .rst(rst), .bus(if3), .tx(tx_w[3]), .busy(bsy_w[3]));

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic push_bits(input logic r, input logic t, input int n);
        repeat (n) exp_q.push_back({r, t});
    endtask

    // Independent frame model: start, LSB-first data, parity from a ones count, stop.
    task automatic push_frame(input int idx, input logic [8:0] d);
        int ones = 0;
        push_bits(1'b0, 1'b0, DIV);
        for (int i = 0; i < nb_t[idx]; i++) begin
            push_bits(1'b0, d[i], DIV);
            if (d[i]) ones++;
        end
        if (pm_t[idx] == PAR_EVEN) push_bits(1'b0, (ones % 2) == 1, DIV);
        if (pm_t[idx] == PAR_ODD)  push_bits(1'b0, (ones % 2) == 0, DIV);
        push_bits(1'b0, 1'b1, DIV * sb_t[idx]);
    endtask

    // Compare n queued clocks of {ready,tx} and busy, then advance one clock each.
    task automatic run(input int idx, input int n, input string tag);
        logic [1:0] e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: observed=queue-empty expected=entry", tag);
                return;
            end
            e = exp_q.pop_front();
            chk(tag, {rdy_w[idx], tx_w[idx]}, e);
            chk({tag, "_busy"}, {1'b0, bsy_w[idx]}, {1'b0, ~e[1]});
            @(posedge clk); #1;
        end
    endtask

    // Offer d once ready; the edge after this call accepts, then sampling starts.
    task automatic send(input int idx, input logic [8:0] d, input bit hold);
        int t = 0;
        while (!rdy_w[idx] && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_wait", {1'b0, rdy_w[idx]}, 2'b01);
        data_d[idx]  = d;
        valid_d[idx] = 1'b1;
        push_frame(idx, d);
        @(posedge clk); #1;
        if (!hold) valid_d[idx] = 1'b0;
    endtask

    task automatic chk_idle(input int idx, input string tag);
        chk(tag, {rdy_w[idx], tx_w[idx]}, 2'b11);
        chk({tag, "_busy"}, {1'b0, bsy_w[idx]}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data_d[i] = '0;
        valid_d = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk_idle(i, "reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 8N1 0x55
        send(0, 9'h055, 1'b0);
        run(0, 160, "8n1_55");
        chk_idle(0, "8n1_55_end");

        // 8E1 / 8O1 0x07
        send(1, 9'h007, 1'b0);
        run(1, 176, "8e1_07");
        chk_idle(1, "8e1_07_end");
        send(2, 9'h007, 1'b0);
        run(2, 176, "8o1_07");
        chk_idle(2, "8o1_07_end");

        // 7N2 0x41
        send(3, 9'h041, 1'b0);
        run(3, 160, "7n2_41");
        chk_idle(3, "7n2_41_end");

        // valid held: 0xA5 then 0x3C, one idle clock between frames
        send(0, 9'h0A5, 1'b1);
        data_d[0] = 9'h03C;
        push_bits(1'b1, 1'b1, 1);
        push_frame(0, 9'h03C);
        run(0, 161, "b2b_first");
        valid_d[0] = 1'b0;
        run(0, 160, "b2b_second");
        chk_idle(0, "b2b_end");

        // 0xFF offered while busy is ignored
        send(0, 9'h055, 1'b0);
        run(0, 40, "busy_pre");
        data_d[0]  = 9'h0FF;
        valid_d[0] = 1'b1;
        run(0, 30, "busy_ignore");
        valid_d[0] = 1'b0;
        run(0, 90, "busy_post");
        chk_idle(0, "busy_end");

        // reset during data bit 3, then a clean 0x0F frame
        send(0, 9'h0C3, 1'b0);
        run(0, 70, "pre_abort");
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle(0, "abort");
        @(posedge clk); #1;
        chk_idle(0, "abort_hold");
        send(0, 9'h00F, 1'b0);
        run(0, 160, "after_abort");
        chk_idle(0, "after_abort_end");

        // reset wins over a simultaneous valid
        data_d[0]  = 9'h012;
        valid_d[0] = 1'b1;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        valid_d[0] = 1'b0;
        chk_idle(0, "rst_valid");
        @(posedge clk); #1;
        chk_idle(0, "rst_valid_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL provide parameter CLOCK_FREQUENCY, default 50000000, input clock rate in Hz.
REQ-002 The block SHALL provide parameter BAUD_RATE, default 115200, line bit rate; bit period DIV = CLOCK_FREQUENCY/BAUD_RATE clocks, integer division.
REQ-003 The block SHALL provide parameter DATA_BITS, default 8, payload width, legal 5..9.
REQ-004 The block SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 The block SHALL provide parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port data, input, DATA_BITS wide, payload.
REQ-009 The block SHALL have port valid, input, 1 bit, payload offered.
REQ-010 The block SHALL have port ready, output, 1 bit, block can accept a payload.
REQ-011 The block SHALL have port tx, output, 1 bit, serial line, idle high.
REQ-012 The block SHALL have port busy, output, 1 bit, frame in progress, equal to ~ready.

Function
REQ-013 The block SHALL accept a payload on a rising edge where valid && ready, latching data into an internal shift register.
REQ-014 The block SHALL ignore data changes after acceptance, and SHALL ignore valid while ready is low, with no queueing.
REQ-015 The block SHALL implement states IDLE -> START -> DATA -> PARITY, skipped when PARITY=0 -> STOP -> IDLE.
REQ-016 The block SHALL drive ready high only in IDLE, and low from the cycle after acceptance.
REQ-017 The block SHALL begin the start bit (tx=0) the cycle after acceptance, with the baud counter cleared at acceptance.
REQ-018 The block SHALL hold every bit for exactly DIV clocks, using a clock-enable tick and no derived clocks.
REQ-019 The block SHALL send data LSB first, DATA_BITS bits; bits above DATA_BITS do not exist.
REQ-020 The block SHALL send a parity bit equal to ^payload for even mode and ~^payload for odd mode.
REQ-021 The block SHALL drive STOP high for STOP_BITS*DIV clocks, then enter IDLE.
REQ-022 The block SHALL keep tx high in IDLE, giving a minimum 1-clock inter-frame gap for back-to-back frames.
REQ-023 The block SHALL track the data-bit index with a counter of width clog2(DATA_BITS+1), with no wrap past DATA_BITS.
REQ-024 The block SHALL fail elaboration on DIV<2, DATA_BITS outside 5..9, PARITY>2, or STOP_BITS outside {1,2}.

Reset
REQ-025 On rst, the block SHALL set in the same clock: state=IDLE, tx=1, ready=1, busy=0, baud counter=0, bit index=0, shift register=0.
REQ-026 On rst mid-frame, the block SHALL abort the frame immediately, with tx high the following cycle and no partial stop/parity emitted.
REQ-027 On rst asserted together with valid, reset SHALL win and the payload SHALL NOT be accepted.

Structure
REQ-028 Parity-mode constants (NONE/ODD/EVEN) and state encodings SHALL live in shared package uart_pkg, for reuse by the matching receiver.
REQ-029 The bit-period tick SHALL be a sub-module baud_gen (parameters CLOCK_FREQUENCY, BAUD_RATE; inputs clk, rst, clear; output tick).
REQ-030 The FSM, shift register and parity logic SHALL remain in uart_tx.

Verification (CLOCK_FREQUENCY=16, BAUD_RATE=1, DIV=16 unless stated)
REQ-031 The bench SHALL cover 8N1, data=0x55: tx = 0,1,0,1,0,1,0,1,0,1, each 16 clks; ready low 160 clks, then high.
REQ-032 The bench SHALL cover 8E1, data=0x07: parity bit=1; with 8O1, same data: parity bit=0; frame 176 clks.
REQ-033 The bench SHALL cover DATA_BITS=7, STOP_BITS=2, data=0x41: data bits 1,0,0,0,0,0,1; tx high 32 clks at end; frame 160 clks.
REQ-034 The bench SHALL cover valid held high with 0xA5 then 0x3C: second start bit begins exactly 161 clks after the first start bit (8N1).
REQ-035 The bench SHALL cover rst pulsed during data bit 3: next cycle tx=1, ready=1; a following send of 0x0F produces a clean, correct frame.
REQ-036 The bench SHALL cover valid with data=0xFF while busy: it is ignored and the in-flight frame's bits are unchanged.
